gamma_row: RTL and testbench
============================

GAMMA_ROW -- requirements
Module: gamma_row

Interface
REQ-001 Parameter WIDTH, default 32, word width in bits.
REQ-002 Parameter NWORDS, default 8, modulus length s in words; legal range 2..256.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a row; sampled only in IDLE.
REQ-006 m_in  input  WIDTH  Montgomery quotient digit m from the preceding beta stage.
REQ-007 c_in  input  WIDTH  carry MSW(t[0] + m*p[0]) from the preceding beta stage.
REQ-008 ts_in  input  WIDTH  accumulator word t[s].
REQ-009 ts1_in  input  WIDTH  accumulator word t[s+1]; only bit 0 is significant.
REQ-010 in_valid  input  1  (t_j, p_j) word pair valid.
REQ-011 in_ready  output  1  block accepts a word pair this cycle.
REQ-012 t_j  input  WIDTH  accumulator word t[j], j = 1..s-1, in ascending order.
REQ-013 p_j  input  WIDTH  modulus word p[j], same order.
REQ-014 out_valid  output  1  result word valid.
REQ-015 out_ready  input  1  downstream accepts result word.
REQ-016 out_data  output  WIDTH  new accumulator word.
REQ-017 out_idx  output  8  destination index of out_data (t[j-1]).
REQ-018 ts_out  output  WIDTH  final t[s]; valid while done=1.
REQ-019 busy  output  1  high from accepted start until done.
REQ-020 done  output  1  one-cycle pulse; row complete.

Function
REQ-021 States SHALL be IDLE, RUN, TAIL, FIN.
REQ-022 IDLE: on start=1, latch m_in, c_in (into carry register C), ts_in, ts1_in[0]; clear word counter j to 1; go RUN; busy=1 next cycle.
REQ-023 start while busy SHALL be ignored without affecting state.
REQ-024 in_ready SHALL equal (state==RUN) and (out_valid==0 or out_ready==1).
REQ-025 Transfer on in_valid & in_ready: sum = t_j + m*p_j + C computed at 2*WIDTH bits (no overflow possible); next cycle out_data=sum[WIDTH-1:0], out_idx=j-1, out_valid=1; C <= sum[2*WIDTH-1:WIDTH]; j increments.
REQ-026 Latency input transfer to out_valid: exactly 1 cycle; sustained throughput 1 word/cycle when out_ready=1.
REQ-027 out_data/out_idx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 After the transfer with j==s-1, go TAIL.
REQ-029 TAIL: when output register free (out_valid==0 or out_ready==1), sum2 = ts + C at WIDTH+1 bits; emit out_data=sum2[WIDTH-1:0], out_idx=s-1; ts_out <= ts1 + sum2[WIDTH] zero-extended to WIDTH; go FIN.
REQ-030 FIN: when TAIL output word accepted (out_valid & out_ready), pulse done=1 for one cycle, busy=0, return to IDLE.
REQ-031 Exactly s result words per row, indices 0..s-1 strictly ascending.
REQ-032 in_valid outside RUN SHALL be ignored.
REQ-033 Simultaneous output acceptance and new input transfer SHALL load the new word with no bubble.
REQ-034 m and C SHALL remain constant across the row except C updating per REQ-025.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE; out_valid, in_ready, busy, done = 0; out_data, out_idx, ts_out, C, m, j = 0.
REQ-036 Reset mid-row SHALL abandon the row; no done pulse; next start begins a fresh row.
REQ-037 First start honoured on the first rising edge after rst_n deasserts.

Verification (WIDTH=8, NWORDS=4)
REQ-038 Basic: m=0x02, c=0x01, ts=0x01, ts1=0x00; pairs (0x10,0x03),(0x00,0x00),(0x00,0x00), out_ready=1 -> out words idx0=0x17, idx1=0x00, idx2=0x00, idx3=0x01; ts_out=0x00; done once.
REQ-039 Max carry: m=0xFF, c=0xFF, all pairs (0xFF,0xFF), ts=0x01, ts1=0x00 -> idx0..2=0xFF each (C stays 0xFF), idx3=0x00, ts_out=0x01.
REQ-040 Backpressure: REQ-038 stimulus with out_ready toggling 1/0 each cycle -> identical words, data stable while stalled, in_ready=0 during stalls.
REQ-041 Input gaps: in_valid low for 3 cycles between pairs -> identical results, no spurious out_valid.
REQ-042 Start while busy and reset mid-row (after idx1 emitted) -> second start ignored; after reset all outputs 0, no done; new row per REQ-038 completes correctly.

Source files
------------

// File: rtl/gamma_row_if.sv
// gamma_row_if -- word-stream handshake bundle for the gamma row stage.
//
// Carries the two streams of the block:
//   input stream : in_valid / in_ready handshake with the (t_j, p_j) word pair
//   output stream: out_valid / out_ready handshake with out_data and its
//                  destination index out_idx
//
// Modports:
//   master - the surrounding datapath (drives word pairs, consumes results)
//   slave  - the gamma_row block itself
interface gamma_row_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] t_j;
    logic [WIDTH-1:0] p_j;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_idx;

    modport master (
        output in_valid, t_j, p_j, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, t_j, p_j, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/gamma_row.sv
// gamma_row -- one row of the Montgomery "gamma" accumulation.
//
// Given the quotient digit m and the incoming carry c from the beta stage,
// streams the modulus/accumulator word pairs j = 1..s-1 and produces the new
// accumulator words t[j-1] = t[j] + m*p[j] + C (carry rippled through C),
// followed by a tail word t[s-1] = t[s] + C and the final top word
// ts_out = t[s+1] + carry.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle row request (honoured only when idle)
//   m_in, c_in              quotient digit and carry from the beta stage
//   ts_in, ts1_in           accumulator words t[s], t[s+1] (bit 0 only)
//   bus (slave)             word-pair input stream and result output stream
//   ts_out                  final t[s], valid while done is high
//   busy                    high from accepted start until done
//   done                    one-cycle row-complete pulse
module gamma_row #(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] m_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] ts_in,
    input  logic [WIDTH-1:0] ts1_in,
    output logic [WIDTH-1:0] ts_out,
    output logic             busy,
    output logic             done,
    gamma_row_if.slave       bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    // Last streamed index (s-1); also the index of the tail word.
    localparam logic [7:0] LAST_J = 8'(NWORDS - 1);

    // t + m*p + c never exceeds 2^(2W)-1, so 2W bits hold it exactly.
    function automatic logic [2*WIDTH-1:0] mac_word(
        input logic [WIDTH-1:0] t,
        input logic [WIDTH-1:0] m,
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] c
    );
        logic [2*WIDTH-1:0] t_x, m_x, p_x, c_x;
        t_x = {{WIDTH{1'b0}}, t};
        m_x = {{WIDTH{1'b0}}, m};
        p_x = {{WIDTH{1'b0}}, p};
        c_x = {{WIDTH{1'b0}}, c};
        return t_x + (m_x * p_x) + c_x;
    endfunction

    function automatic logic [WIDTH:0] add_carry(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [1:0]         state;
    logic [WIDTH-1:0]   m_p0;
    logic [WIDTH-1:0]   c_p0;
    logic [WIDTH-1:0]   ts_p0;
    logic               ts1_p0;
    logic [7:0]         j_p0;

    logic               vld_p1;
    logic [WIDTH-1:0]   out_data_p1;
    logic [7:0]         out_idx_p1;

    logic [2*WIDTH-1:0] sum_p0;
    logic [WIDTH:0]     sum2_p0;
    logic               out_free;
    logic               in_ready_int;
    logic               unused_ts1_hi;

    // Only bit 0 of t[s+1] can be nonzero at this point of the algorithm.
    assign unused_ts1_hi = ^ts1_in[WIDTH-1:1];

    assign out_free     = !vld_p1 || bus.out_ready;
    assign in_ready_int = (state == RUN) && out_free;

    assign sum_p0  = mac_word(bus.t_j, m_p0, bus.p_j, c_p0);
    assign sum2_p0 = add_carry(ts_p0, c_p0);

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = out_data_p1;
    assign bus.out_idx   = out_idx_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_p0        <= '0;
            c_p0        <= '0;
            ts_p0       <= '0;
            ts1_p0      <= 1'b0;
            j_p0        <= '0;
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
            out_idx_p1  <= '0;
            ts_out      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            // Accepted word leaves the output register unless a new word
            // is loaded below in the same cycle (no bubble).
            if (vld_p1 && bus.out_ready) begin
                vld_p1 <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        m_p0   <= m_in;
                        c_p0   <= c_in;
                        ts_p0  <= ts_in;
                        ts1_p0 <= ts1_in[0];
                        j_p0   <= 8'd1;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end

                // p0 -> p1: word pair to result register, carry kept in C
                RUN: begin
                    if (bus.in_valid && in_ready_int) begin
                        out_data_p1 <= sum_p0[WIDTH-1:0];
                        out_idx_p1  <= j_p0 - 8'd1;
                        vld_p1      <= 1'b1;
                        c_p0        <= sum_p0[2*WIDTH-1:WIDTH];
                        j_p0        <= j_p0 + 8'd1;
                        if (j_p0 == LAST_J) begin
                            state <= TAIL;
                        end
                    end
                end

                TAIL: begin
                    if (out_free) begin
                        out_data_p1 <= sum2_p0[WIDTH-1:0];
                        out_idx_p1  <= LAST_J;
                        vld_p1      <= 1'b1;
                        ts_out      <= {{(WIDTH-1){1'b0}}, ts1_p0} +
                                       {{(WIDTH-1){1'b0}}, sum2_p0[WIDTH]};
                        state       <= FIN;
                    end
                end

                FIN: begin
                    if (vld_p1 && bus.out_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gamma_row.sv
module tb_gamma_row;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] m_in, c_in, ts_in, ts1_in;
    logic [W-1:0] ts_out;
    logic         busy, done;

    gamma_row_if #(.WIDTH(W)) bus ();

    gamma_row #(.WIDTH(W), .NWORDS(S)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .m_in   (m_in),
        .c_in   (c_in),
        .ts_in  (ts_in),
        .ts1_in (ts1_in),
        .ts_out (ts_out),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // row stimulus
    logic [7:0] r_m, r_c, r_ts, r_ts1;
    logic [7:0] r_t [1:3];
    logic [7:0] r_p [1:3];
    int         rdy_mode;   // 0: always ready, 1: toggle, 2: random
    int         gap_len;

    // collected results
    logic [7:0] got_data [$];
    logic [7:0] got_idx  [$];
    int         done_cnt;
    logic [7:0] got_ts;
    int         stall_err;
    int         ready_err;

    // expected results
    logic [7:0] exp_w [0:3];
    logic [7:0] exp_ts;

    // Whole row as one integer: words are little-endian digits of
    // c + sum (t_j + m*p_j)*B^(j-1) + (ts + ts1*B)*B^(s-1).
    function automatic void model();
        longint unsigned v;
        v = 64'(r_c);
        for (int j = 1; j <= 3; j++)
            v += (64'(r_t[j]) + 64'(r_m) * 64'(r_p[j])) << (8 * (j - 1));
        v += (64'(r_ts) + (64'(r_ts1[0]) << 8)) << 24;
        for (int i = 0; i < 4; i++) exp_w[i] = v[8*i +: 8];
        exp_ts = v[39:32];
    endfunction

    task automatic set_basic();
        r_m = 8'h02; r_c = 8'h01; r_ts = 8'h01; r_ts1 = 8'h00;
        r_t[1] = 8'h10; r_p[1] = 8'h03;
        r_t[2] = 8'h00; r_p[2] = 8'h00;
        r_t[3] = 8'h00; r_p[3] = 8'h00;
    endtask

    task automatic run_row();
        int   k, gapcnt, tail;
        logic tog, prev_stall;
        logic [7:0] prev_d, prev_i;
        got_data.delete(); got_idx.delete();
        done_cnt = 0; stall_err = 0; ready_err = 0; got_ts = 8'hxx;
        prev_stall = 1'b0; prev_d = '0; prev_i = '0; tog = 1'b1;
        @(negedge clk);
        start = 1'b1; m_in = r_m; c_in = r_c; ts_in = r_ts;
        ts1_in = {7'($urandom), r_ts1[0]};
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_in = 8'($urandom); c_in = 8'($urandom); ts_in = 8'($urandom); ts1_in = 8'($urandom);
        k = 1; gapcnt = 0; tail = -1;
        for (int cyc = 0; cyc < 200 && tail != 0; cyc++) begin
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       begin bus.out_ready = tog; tog = !tog; end
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (k <= 3 && gapcnt == 0) begin
                bus.in_valid = 1'b1; bus.t_j = r_t[k]; bus.p_j = r_p[k];
            end else begin
                bus.in_valid = 1'b0; bus.t_j = 8'($urandom); bus.p_j = 8'($urandom);
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_idx.push_back(bus.out_idx);
            end
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_d || bus.out_idx !== prev_i))
                stall_err++;
            if (bus.out_valid && !bus.out_ready && bus.in_ready) ready_err++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d = bus.out_data; prev_i = bus.out_idx;
            if (done) begin
                done_cnt++; got_ts = ts_out;
                if (tail < 0) tail = 4;
            end
            if (bus.in_valid && bus.in_ready) begin k++; gapcnt = gap_len; end
            else if (!bus.in_valid && gapcnt > 0) gapcnt--;
            if (tail > 0) tail--;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        rst_n = 1'b0; start = 1'b0; m_in = '0; c_in = '0; ts_in = '0; ts1_in = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.t_j = '0; bus.p_j = '0;
        #13;
        outs = {bus.out_valid, bus.in_ready, busy, done, bus.out_data, bus.out_idx, ts_out, 4'h0};
        total++;
        if (outs !== 32'h0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
        // first start honoured on the first edge after release
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; m_in = 8'h02; c_in = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL first_start_busy got=%b want=1", busy); end
        // asynchronous reset in the middle of a cycle
        #2; rst_n = 1'b0; #1;
        outs = {bus.out_valid, bus.in_ready, busy, done, bus.out_data, bus.out_idx, ts_out, 4'h0};
        total++;
        if (outs !== 32'h0) begin bad++; $display("FAIL async_reset got=%h want=0", outs); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_basic(); rdy_mode = 0; gap_len = 0;
        exp_w[0] = 8'h17; exp_w[1] = 8'h00; exp_w[2] = 8'h00; exp_w[3] = 8'h01; exp_ts = 8'h00;
        run_row();
        total++;
        if (got_data.size() !== 4) begin bad++; $display("FAIL basic_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++;
            if (got_idx[i] !== 8'(i) || got_data[i] !== exp_w[i]) begin
                bad++; $display("FAIL basic_word%0d got=idx%0d:%h want=idx%0d:%h", i, got_idx[i], got_data[i], i, exp_w[i]);
            end
        end
        total++;
        if (got_ts !== exp_ts) begin bad++; $display("FAIL basic_ts_out got=%h want=%h", got_ts, exp_ts); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL basic_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_max_carry();
        r_m = 8'hFF; r_c = 8'hFF; r_ts = 8'h01; r_ts1 = 8'h00;
        for (int j = 1; j <= 3; j++) begin r_t[j] = 8'hFF; r_p[j] = 8'hFF; end
        rdy_mode = 0; gap_len = 0;
        exp_w[0] = 8'hFF; exp_w[1] = 8'hFF; exp_w[2] = 8'hFF; exp_w[3] = 8'h00; exp_ts = 8'h01;
        run_row();
        total++;
        if (got_data.size() !== 4) begin bad++; $display("FAIL maxc_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++;
            if (got_idx[i] !== 8'(i) || got_data[i] !== exp_w[i]) begin
                bad++; $display("FAIL maxc_word%0d got=idx%0d:%h want=idx%0d:%h", i, got_idx[i], got_data[i], i, exp_w[i]);
            end
        end
        total++;
        if (got_ts !== exp_ts) begin bad++; $display("FAIL maxc_ts_out got=%h want=%h", got_ts, exp_ts); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL maxc_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        set_basic(); rdy_mode = 1; gap_len = 0;
        model();
        run_row();
        total++;
        if (got_data.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++;
            if (got_idx[i] !== 8'(i) || got_data[i] !== exp_w[i]) begin
                bad++; $display("FAIL bp_word%0d got=idx%0d:%h want=idx%0d:%h", i, got_idx[i], got_data[i], i, exp_w[i]);
            end
        end
        total++;
        if (stall_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d changes want=0", stall_err); end
        total++;
        if (ready_err !== 0) begin bad++; $display("FAIL bp_in_ready got=%0d stalled-ready cycles want=0", ready_err); end
        total++;
        if (got_ts !== exp_ts || done_cnt !== 1) begin
            bad++; $display("FAIL bp_final got=ts%h/done%0d want=ts%h/done1", got_ts, done_cnt, exp_ts);
        end
    endtask

    task automatic test_gaps();
        set_basic(); rdy_mode = 0; gap_len = 3;
        model();
        run_row();
        total++;
        if (got_data.size() !== 4) begin bad++; $display("FAIL gap_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++;
            if (got_idx[i] !== 8'(i) || got_data[i] !== exp_w[i]) begin
                bad++; $display("FAIL gap_word%0d got=idx%0d:%h want=idx%0d:%h", i, got_idx[i], got_data[i], i, exp_w[i]);
            end
        end
        total++;
        if (got_ts !== exp_ts || done_cnt !== 1) begin
            bad++; $display("FAIL gap_final got=ts%h/done%0d want=ts%h/done1", got_ts, done_cnt, exp_ts);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            r_m = 8'($urandom); r_c = 8'($urandom); r_ts = 8'($urandom); r_ts1 = 8'($urandom_range(0, 1));
            for (int j = 1; j <= 3; j++) begin r_t[j] = 8'($urandom); r_p[j] = 8'($urandom); end
            rdy_mode = (r < 2) ? 0 : 2;
            gap_len  = $urandom_range(0, 2);
            model();
            run_row();
            total++;
            if (got_data.size() !== 4) begin bad++; $display("FAIL rnd%0d_count got=%0d want=4", r, got_data.size()); end
            for (int i = 0; i < got_data.size() && i < 4; i++) begin
                total++;
                if (got_idx[i] !== 8'(i) || got_data[i] !== exp_w[i]) begin
                    bad++; $display("FAIL rnd%0d_word%0d got=idx%0d:%h want=idx%0d:%h", r, i, got_idx[i], got_data[i], i, exp_w[i]);
                end
            end
            total++;
            if (got_ts !== exp_ts || done_cnt !== 1) begin
                bad++; $display("FAIL rnd%0d_final got=ts%h/done%0d want=ts%h/done1", r, got_ts, done_cnt, exp_ts);
            end
            total++;
            if (stall_err !== 0 || ready_err !== 0) begin
                bad++; $display("FAIL rnd%0d_stall got=%0d/%0d want=0/0", r, stall_err, ready_err);
            end
        end
    endtask

    task automatic test_busy_start_and_reset();
        int   k, seen_done;
        logic hit;
        logic [31:0] outs;
        set_basic();
        got_data.delete(); got_idx.delete();
        @(negedge clk);
        start = 1'b1; m_in = r_m; c_in = r_c; ts_in = r_ts; ts1_in = r_ts1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1; hit = 1'b0;
        for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
            bus.out_ready = 1'b1;
            start = (cyc == 1);
            m_in = 8'hFF; c_in = 8'hFF; ts_in = 8'hFF; ts1_in = 8'hFF;
            if (k <= 3) begin bus.in_valid = 1'b1; bus.t_j = r_t[k]; bus.p_j = r_p[k]; end
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin got_data.push_back(bus.out_data); got_idx.push_back(bus.out_idx); end
            if (bus.out_valid && bus.out_idx == 8'd1) hit = 1'b1;
            if (bus.in_valid && bus.in_ready) k++;
            if (!hit) @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (got_data.size() !== 2) begin bad++; $display("FAIL busy_count got=%0d want=2", got_data.size()); end
        else begin
            total++;
            if (got_data[0] !== 8'h17 || got_data[1] !== 8'h00 || got_idx[1] !== 8'd1) begin
                bad++; $display("FAIL busy_start_ignored got=%h,%h want=17,00", got_data[0], got_data[1]);
            end
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_midrow got=%b want=1", busy); end
        #2; rst_n = 1'b0; #1;
        bus.in_valid = 1'b0;
        outs = {bus.out_valid, bus.in_ready, busy, done, bus.out_data, bus.out_idx, ts_out, 4'h0};
        total++;
        if (outs !== 32'h0) begin bad++; $display("FAIL midrow_reset got=%h want=0", outs); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk); #1;
            if (done || bus.out_valid || busy) seen_done++;
        end
        total++;
        if (seen_done !== 0) begin bad++; $display("FAIL abandoned_row got=%0d active cycles want=0", seen_done); end
        set_basic(); rdy_mode = 0; gap_len = 0;
        model();
        run_row();
        total++;
        if (got_data.size() !== 4) begin bad++; $display("FAIL fresh_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++;
            if (got_idx[i] !== 8'(i) || got_data[i] !== exp_w[i]) begin
                bad++; $display("FAIL fresh_word%0d got=idx%0d:%h want=idx%0d:%h", i, got_idx[i], got_data[i], i, exp_w[i]);
            end
        end
        total++;
        if (got_ts !== exp_ts || done_cnt !== 1) begin
            bad++; $display("FAIL fresh_final got=ts%h/done%0d want=ts%h/done1", got_ts, done_cnt, exp_ts);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_carry();
        test_backpressure();
        test_gaps();
        test_random();
        test_busy_start_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
